restoring_divider_8x4: RTL and testbench

Sequential restoring divider that inverts the 4x4 multiplier path: it takes an 8-bit dividend (a multiplier-width product) and a 4-bit divisor and returns quotient and remainder, one quotient bit per clock. It sits beside the vedic multiplier blocks in the arithmetic library. It gives a start/done-handshaked check and inverse path for product words, and a way to recover an operand from a product.

---
 rtl/restoring_divider_8x4_if.sv | 24 ++
 rtl/restoring_divider_8x4.sv | 104 ++++++++++
 tb/tb_restoring_divider_8x4.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_8x4_if.sv
// rtl/restoring_divider_8x4_if.sv - start/done handshake and operand/result bundle for the divider
interface restoring_divider_8x4_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/restoring_divider_8x4.sv
// rtl/restoring_divider_8x4.sv - sequential restoring divider, one quotient bit per clock
module restoring_divider_8x4 #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   restoring_divider_8x4_if.slave bus
);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_next;
   logic [DW-1:0] q_reg;
   logic [VW-1:0] d_reg;
   // After each restoring step R < D, so its top bit is always zero and need not be stored.
   logic [VW-1:0] r_reg;
   logic [CW-1:0] count;
   logic [DW-1:0] quotient_reg;
   logic [VW-1:0] remainder_reg;
   logic          dbz_reg;

   logic [VW:0]   shifted;
   logic [VW:0]   trial;
   logic [DW-1:0] q_step;
   logic [VW:0]   r_step;
   logic          accept;
   logic          last_iter;

   always_comb begin
      shifted   = {r_reg, q_reg[DW-1]};
      trial     = shifted - {1'b0, d_reg};
      q_step    = {q_reg[DW-2:0], ~trial[VW]};
      r_step    = trial[VW] ? shifted : trial;
      accept    = bus.start && (state == IDLE || state == DONE);
      last_iter = (state == RUN) && (count == CW'(1));
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start)
               state_next = (bus.divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            if (count == CW'(1))
               state_next = DONE;
         end
         DONE: begin
            if (bus.start)
               state_next = (bus.divisor == '0) ? DONE : RUN;
            else
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg         <= '0;
         d_reg         <= '0;
         r_reg         <= '0;
         count         <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else if (accept) begin
         q_reg   <= bus.dividend;
         d_reg   <= bus.divisor;
         r_reg   <= '0;
         count   <= CW'(DW);
         dbz_reg <= (bus.divisor == '0);
         // Divide by zero skips the iterations and publishes its fixed result at the accept edge.
         if (bus.divisor == '0) begin
            quotient_reg  <= '1;
            remainder_reg <= bus.dividend[VW-1:0];
         end
      end else if (state == RUN) begin
         q_reg <= q_step;
         r_reg <= r_step[VW-1:0];
         count <= count - CW'(1);
         if (last_iter) begin
            quotient_reg  <= q_step;
            remainder_reg <= r_step[VW-1:0];
         end
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quotient_reg;
   assign bus.remainder   = remainder_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_restoring_divider_8x4.sv
// tb/tb_restoring_divider_8x4.sv - directed self-checking bench for restoring_divider_8x4
module tb_restoring_divider_8x4;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   lat;
   int   busy_cnt;
   int   seen;

   restoring_divider_8x4_if #(.DW(8), .VW(4)) bus ();

   restoring_divider_8x4 #(.DW(8), .VW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for done after the start was already applied at the current edge.
   task automatic wait_done(output int lat_o, output int busy_o);
      lat_o  = 0;
      busy_o = 0;
      while (!bus.done && lat_o < 20) begin
         if (bus.busy) busy_o++;
         tick();
         lat_o++;
      end
      chk("done_seen", longint'(bus.done), 1);
   endtask

   task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int lat_o, output int busy_o);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      tick();
      bus.start = 1'b0;
      wait_done(lat_o, busy_o);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("rst_busy", longint'(bus.busy), 0);
      chk("rst_done", longint'(bus.done), 0);
      chk("rst_quot", longint'(bus.quotient), 0);
      chk("rst_rem", longint'(bus.remainder), 0);
      chk("rst_dbz", longint'(bus.div_by_zero), 0);

      run_div(8'd200, 4'd7, lat, busy_cnt);
      chk("d200_7_lat", lat, 8);
      chk("d200_7_busy_cycles", busy_cnt, 8);
      chk("d200_7_busy_in_done", longint'(bus.busy), 0);
      chk("d200_7_quot", longint'(bus.quotient), 28);
      chk("d200_7_rem", longint'(bus.remainder), 4);
      chk("d200_7_dbz", longint'(bus.div_by_zero), 0);
      tick();
      chk("d200_7_done_width", longint'(bus.done), 0);

      run_div(8'd255, 4'd15, lat, busy_cnt);
      chk("d255_15_quot", longint'(bus.quotient), 17);
      chk("d255_15_rem", longint'(bus.remainder), 0);
      run_div(8'd143, 4'd11, lat, busy_cnt);
      chk("d143_11_quot", longint'(bus.quotient), 13);
      chk("d143_11_rem", longint'(bus.remainder), 0);
      run_div(8'd3, 4'd9, lat, busy_cnt);
      chk("d3_9_quot", longint'(bus.quotient), 0);
      chk("d3_9_rem", longint'(bus.remainder), 3);
      tick();

      run_div(8'd5, 4'd0, lat, busy_cnt);
      chk("d5_0_lat", lat, 0);
      chk("d5_0_quot", longint'(bus.quotient), 255);
      chk("d5_0_rem", longint'(bus.remainder), 5);
      chk("d5_0_dbz", longint'(bus.div_by_zero), 1);
      tick();
      chk("d5_0_done_width", longint'(bus.done), 0);
      chk("d5_0_dbz_held", longint'(bus.div_by_zero), 1);
      run_div(8'd100, 4'd3, lat, busy_cnt);
      chk("d100_3_quot", longint'(bus.quotient), 33);
      chk("d100_3_rem", longint'(bus.remainder), 1);
      chk("d100_3_dbz", longint'(bus.div_by_zero), 0);
      tick();

      // Start while running is ignored; start in the done cycle is accepted.
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 4'd7;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      bus.start    = 1'b1;
      bus.dividend = 8'd9;
      bus.divisor  = 4'd3;
      tick();
      bus.start = 1'b0;
      wait_done(lat, busy_cnt);
      chk("ignore_lat", lat + 3, 8);
      chk("ignore_quot", longint'(bus.quotient), 28);
      chk("ignore_rem", longint'(bus.remainder), 4);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("b2b_busy", longint'(bus.busy), 1);
      chk("b2b_done", longint'(bus.done), 0);
      chk("b2b_quot_held", longint'(bus.quotient), 28);
      chk("b2b_rem_held", longint'(bus.remainder), 4);
      repeat (4) tick();
      chk("b2b_quot_held_mid", longint'(bus.quotient), 28);
      wait_done(lat, busy_cnt);
      chk("b2b_lat", lat + 4, 8);
      chk("b2b_quot", longint'(bus.quotient), 3);
      chk("b2b_rem", longint'(bus.remainder), 0);
      tick();

      // Asynchronous reset in the middle of a run.
      bus.start    = 1'b1;
      bus.dividend = 8'd255;
      bus.divisor  = 4'd15;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", longint'(bus.busy), 0);
      chk("midrst_done", longint'(bus.done), 0);
      chk("midrst_quot", longint'(bus.quotient), 0);
      chk("midrst_rem", longint'(bus.remainder), 0);
      chk("midrst_dbz", longint'(bus.div_by_zero), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         tick();
         if (bus.done || bus.busy) seen = 1;
      end
      chk("midrst_no_activity", seen, 0);
      run_div(8'd60, 4'd4, lat, busy_cnt);
      chk("d60_4_quot", longint'(bus.quotient), 15);
      chk("d60_4_rem", longint'(bus.remainder), 0);
      tick();

      // Products of the 4x4 multiplier must divide back to the operand.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_div(8'(a * b), 4'(b), lat, busy_cnt);
            if (b == 0) begin
               chk("prod_dbz", longint'(bus.div_by_zero), 1);
               chk("prod_dbz_quot", longint'(bus.quotient), 255);
            end else begin
               chk("prod_quot", longint'(bus.quotient), a);
               chk("prod_rem", longint'(bus.remainder), 0);
            end
         end
      end

      for (int i = 0; i < 40; i++) begin
         logic [7:0] dv;
         logic [3:0] ds;
         dv = 8'($urandom_range(255, 0));
         ds = 4'($urandom_range(15, 1));
         run_div(dv, ds, lat, busy_cnt);
         chk("rand_identity", longint'(bus.quotient) * ds + longint'(bus.remainder), dv);
         chk("rand_rem_lt_div", longint'(bus.remainder < ds), 1);
      end

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
